// File: rtl/bus_fifo_slave.sv
// bus_fifo_slave
// Memory-mapped FIFO peripheral for the single-master bus. The master pushes
// a word by writing the DATA register and pops one by reading it. STATUS,
// CTRL and THRESH registers plus a level interrupt allow either polling or
// interrupt-driven draining.
//
// Access protocol: there is no handshake and no back-pressure. Each rising
// clock edge that samples s_sel=1 is exactly one access, qualified by s_wr
// and s_addr[2:0]. An access always completes in that cycle. Read data is
// registered on the same edge and is valid from the following cycle until
// the next read. Writes never disturb s_dout.
//
// Register map (offset = s_addr[2:0]):
//   0 DATA   W: push s_din (dropped and ovf set when full)
//            R: pop head (returns 0 and sets udf when empty)
//   1 STATUS R: [0] empty [1] full [2] ovf [3] udf [8 +: CNT_W] count
//   2 CTRL   W: [0] flush  [1] irq_en  [2] clear ovf/udf
//            R: [1] irq_en, all other bits 0
//   3 THRESH R/W: [CNT_W-1:0]
//   4-7      R: 0, W: ignored

module bus_fifo_slave #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              irq
);

    // Pointer and occupancy widths: count needs one extra bit to hold DEPTH.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_THRESH = 3'd3;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              ovf_q,     ovf_d;
    logic              udf_q,     udf_d;
    logic              irq_en_q,  irq_en_d;
    logic [CNT_W-1:0]  thresh_q,  thresh_d;
    logic [DATA_W-1:0] dout_q,    dout_d;
    logic              irq_q,     irq_d;

    logic              mem_we;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic [2:0] off;
    logic       wr_acc;
    logic       rd_acc;
    logic       fifo_empty;
    logic       fifo_full;

    // Only the low three address bits select a register; the rest are ignored.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^s_addr[ADDR_W-1:3];

    assign off        = s_addr[2:0];
    assign wr_acc     = s_sel & s_wr;
    assign rd_acc     = s_sel & ~s_wr;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // ------------------------------------------------------------------
    // Register read data for the non-FIFO offsets
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] reg_rdata;

    // Assemble the STATUS word from current flags and occupancy.
    always_comb begin
        status_word               = '0;
        status_word[0]            = fifo_empty;
        status_word[1]            = fifo_full;
        status_word[2]            = ovf_q;
        status_word[3]            = udf_q;
        status_word[8 +: CNT_W]   = count_q;
    end

    // Select read data for STATUS/CTRL/THRESH and the unmapped offsets.
    always_comb begin
        reg_rdata = '0;
        case (off)
            OFF_STATUS: reg_rdata = status_word;
            OFF_CTRL:   reg_rdata[1] = irq_en_q;
            OFF_THRESH: reg_rdata[CNT_W-1:0] = thresh_q;
            default:    reg_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic: one access per cycle updates FIFO, flags and s_dout
    // ------------------------------------------------------------------
    // Compute the effect of the current access on every piece of state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        dout_d   = dout_q;
        mem_we   = 1'b0;

        if (wr_acc) begin
            case (off)
                OFF_DATA: begin
                    if (!fifo_full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                OFF_CTRL: begin
                    // Flush, enable and flag-clear may all be set in one write.
                    if (s_din[0]) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        count_d  = '0;
                    end
                    irq_en_d = s_din[1];
                    if (s_din[2]) begin
                        ovf_d = 1'b0;
                        udf_d = 1'b0;
                    end
                end
                OFF_THRESH: begin
                    thresh_d = s_din[CNT_W-1:0];
                end
                default: begin
                    // STATUS and unmapped offsets ignore writes.
                end
            endcase
        end else if (rd_acc) begin
            if (off == OFF_DATA) begin
                if (!fifo_empty) begin
                    dout_d   = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end else begin
                    dout_d = '0;
                    udf_d  = 1'b1;
                end
            end else begin
                dout_d = reg_rdata;
            end
        end
    end

    // Interrupt level is evaluated on next-state values so it tracks the
    // access that just completed without an extra cycle of lag.
    always_comb begin
        irq_d = irq_en_d &
                (((thresh_d != '0) & (count_d >= thresh_d)) | ovf_d | udf_d);
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // Control state with asynchronous reset; an access in flight is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            dout_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            dout_q   <= dout_d;
            irq_q    <= irq_d;
        end
    end

    // Storage array is not reset; a stale entry is unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= s_din;
        end
    end

    assign s_dout = dout_q;
    assign irq    = irq_q;

endmodule
